// File: rtl/mvu_pe_popcount_acc.sv
// mvu_pe_popcount_acc: sums SF popcount beats into one TO-bit result on a registered valid/ready port (MVAU_POPCOUNT_BIPOLAR_EN selects the +/-1 mapping)
module mvu_pe_popcount_acc #(
  parameter int TI   = 2,
  parameter int TO   = 8,
  parameter int SIMD = 2,
  parameter int SF   = 4
) (
  input  logic          aclk,
  input  logic          rst,
  input  logic          in_v,
  output logic          in_rdy,
  input  logic [TI-1:0] in_add,
  output logic          out_v,
  input  logic          out_rdy,
  output logic [TO-1:0] out_acc
);
  localparam int CW = SF > 1 ? $clog2(SF) : 1;
`ifdef MVAU_POPCOUNT_BIPOLAR_EN
  localparam int BIP = 1;
`else
  localparam int BIP = 0;
`endif
  generate
    if (SF < 1 || TO < $clog2(SIMD * SF + 1) + BIP) begin : g_bad_cfg
      $error("mvu_pe_popcount_acc: SF must be >= 1 and TO wide enough for SIMD*SF");
    end
  endgenerate
  typedef enum logic {ACC, HOLD} state_t;
  state_t state, state_nx;
  logic [CW-1:0] sf_cnt;
  logic [TO-1:0] acc, add, sum, res;
  logic beat, last;
  assign out_v  = state == HOLD;
  assign in_rdy = ~out_v | out_rdy;
  assign beat   = in_v & in_rdy;
  assign last   = sf_cnt == CW'(SF - 1);
  assign add    = TO'(in_add);
  // with SF==1 every beat is a whole fold, so the running sum never contributes
  assign sum    = (SF == 1 ? '0 : acc) + add;
`ifdef MVAU_POPCOUNT_BIPOLAR_EN
  // popcount p of n XNOR lanes maps to the +/-1 dot product 2p - n
  assign res    = (sum << 1) - TO'(SIMD * SF);
`else
  assign res    = sum;
`endif
  // state register: out_v is the HOLD state itself, so it comes straight from a flop
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) state <= ACC;
    else     state <= state_nx;
  end
  // a final beat always (re)loads the output; otherwise a taken output frees the slot
  always_comb begin
    state_nx = (beat && last) ? HOLD : out_rdy ? ACC : state;
  end
  // fold counter, running sum and output word advance only on accepted beats
  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      sf_cnt  <= '0;
      acc     <= '0;
      out_acc <= '0;
    end else if (beat) begin
      sf_cnt <= last ? '0 : CW'(sf_cnt + 1'b1);
      acc    <= sf_cnt == '0 ? add : acc + add;
      if (last) out_acc <= res;
    end
  end
endmodule

// File: tb/tb_mvu_pe_popcount_acc.sv
// tb_mvu_pe_popcount_acc: directed checks of the popcount accumulator (SIMD=8/SF=4 and SIMD=2/SF=1 instances)
module tb_mvu_pe_popcount_acc;
`ifdef MVAU_POPCOUNT_BIPOLAR_EN
  localparam int BIP = 1;
`else
  localparam int BIP = 0;
`endif
  logic aclk = 0, rst = 1;
  logic a_in_v = 0, a_in_rdy, a_out_v, a_out_rdy = 1;
  logic [3:0] a_in_add = 0;
  logic [7:0] a_out_acc;
  logic b_in_v = 0, b_in_rdy, b_out_v, b_out_rdy = 1;
  logic [1:0] b_in_add = 0;
  logic [7:0] b_out_acc;
  int tests = 0, fails = 0;

  always #5 aclk = ~aclk;

  mvu_pe_popcount_acc #(.TI(4), .TO(8), .SIMD(8), .SF(4)) u_a (
    .aclk(aclk), .rst(rst), .in_v(a_in_v), .in_rdy(a_in_rdy), .in_add(a_in_add),
    .out_v(a_out_v), .out_rdy(a_out_rdy), .out_acc(a_out_acc));
  mvu_pe_popcount_acc #(.TI(2), .TO(8), .SIMD(2), .SF(1)) u_b (
    .aclk(aclk), .rst(rst), .in_v(b_in_v), .in_rdy(b_in_rdy), .in_add(b_in_add),
    .out_v(b_out_v), .out_rdy(b_out_rdy), .out_acc(b_out_acc));

  function automatic logic [7:0] fx(input int x, input int n);
    return 8'(BIP ? 2 * x - n : x);
  endfunction

  task automatic beat_a(input logic v, input logic [3:0] d);
    a_in_v = v; a_in_add = d;
    @(posedge aclk); #1;
  endtask

  task automatic beat_b(input logic v, input logic [1:0] d);
    b_in_v = v; b_in_add = d;
    @(posedge aclk); #1;
  endtask

  task automatic test_reset;
    #12;
    tests++; if (a_out_v !== 1'b0 || a_out_acc !== 8'h00 || a_in_rdy !== 1'b1) begin fails++;
      $display("FAIL reset_a got v=%b acc=%h rdy=%b want v=0 acc=00 rdy=1", a_out_v, a_out_acc, a_in_rdy); end
    tests++; if (b_out_v !== 1'b0 || b_out_acc !== 8'h00) begin fails++;
      $display("FAIL reset_b got v=%b acc=%h want v=0 acc=00", b_out_v, b_out_acc); end
    @(posedge aclk); #1 rst = 0;
  endtask

  task automatic test_fold;
    int vec [3][4] = '{'{3, 5, 0, 8}, '{8, 8, 8, 8}, '{0, 0, 0, 0}};
    int tot [3] = '{16, 32, 0};
    a_out_rdy = 1;
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 4; i++) begin
        tests++; if (a_in_rdy !== 1'b1) begin fails++;
          $display("FAIL fold%0d_in_rdy beat %0d got %b want 1", t, i, a_in_rdy); end
        beat_a(1, 4'(vec[t][i]));
        if (i < 3) begin
          tests++; if (a_out_v !== 1'b0) begin fails++;
            $display("FAIL fold%0d_early_v beat %0d got %b want 0", t, i, a_out_v); end
        end
      end
      tests++; if (a_out_v !== 1'b1 || a_out_acc !== fx(tot[t], 32)) begin fails++;
        $display("FAIL fold%0d_result got v=%b acc=%h want v=1 acc=%h", t, a_out_v, a_out_acc, fx(tot[t], 32)); end
      beat_a(0, 0);
      tests++; if (a_out_v !== 1'b0 || a_out_acc !== fx(tot[t], 32)) begin fails++;
        $display("FAIL fold%0d_drain got v=%b acc=%h want v=0 acc=%h", t, a_out_v, a_out_acc, fx(tot[t], 32)); end
    end
  endtask

  task automatic test_back_to_back;
    int vec [8] = '{3, 5, 0, 8, 4, 4, 4, 8};
    a_out_rdy = 1;
    for (int i = 0; i < 8; i++) begin
      tests++; if (a_in_rdy !== 1'b1) begin fails++;
        $display("FAIL b2b_in_rdy beat %0d got %b want 1", i, a_in_rdy); end
      beat_a(1, 4'(vec[i]));
      tests++; if (a_out_v !== (i == 3 || i == 7)) begin fails++;
        $display("FAIL b2b_v beat %0d got %b want %b", i, a_out_v, i == 3 || i == 7); end
      if (i >= 3) begin
        tests++; if (a_out_acc !== fx(i == 7 ? 20 : 16, 32)) begin fails++;
          $display("FAIL b2b_acc beat %0d got %h want %h", i, a_out_acc, fx(i == 7 ? 20 : 16, 32)); end
      end
    end
    beat_a(0, 0);
  endtask

  task automatic test_backpressure;
    a_out_rdy = 0;
    beat_a(1, 3); beat_a(1, 5); beat_a(1, 0); beat_a(1, 8);
    a_in_v = 1; a_in_add = 1;
    for (int i = 0; i < 5; i++) begin
      tests++; if (a_in_rdy !== 1'b0 || a_out_v !== 1'b1 || a_out_acc !== fx(16, 32)) begin fails++;
        $display("FAIL bp_hold cycle %0d got rdy=%b v=%b acc=%h want rdy=0 v=1 acc=%h", i, a_in_rdy, a_out_v, a_out_acc, fx(16, 32)); end
      @(posedge aclk); #1;
    end
    a_out_rdy = 1; #1;
    tests++; if (a_in_rdy !== 1'b1) begin fails++;
      $display("FAIL bp_release in_rdy got %b want 1", a_in_rdy); end
    beat_a(1, 1);
    tests++; if (a_out_v !== 1'b0) begin fails++;
      $display("FAIL bp_slot_freed out_v got %b want 0", a_out_v); end
    beat_a(1, 1); beat_a(1, 1); beat_a(1, 1);
    tests++; if (a_out_v !== 1'b1 || a_out_acc !== fx(4, 32)) begin fails++;
      $display("FAIL bp_next_fold got v=%b acc=%h want v=1 acc=%h", a_out_v, a_out_acc, fx(4, 32)); end
    beat_a(0, 0);
  endtask

  task automatic test_sf1;
    int vec [3] = '{2, 1, 0};
    b_out_rdy = 1;
    for (int i = 0; i < 3; i++) begin
      tests++; if (b_in_rdy !== 1'b1) begin fails++;
        $display("FAIL sf1_in_rdy beat %0d got %b want 1", i, b_in_rdy); end
      beat_b(1, 2'(vec[i]));
      tests++; if (b_out_v !== 1'b1 || b_out_acc !== fx(vec[i], 2)) begin fails++;
        $display("FAIL sf1_result beat %0d got v=%b acc=%h want v=1 acc=%h", i, b_out_v, b_out_acc, fx(vec[i], 2)); end
    end
    beat_b(0, 0);
    tests++; if (b_out_v !== 1'b0) begin fails++;
      $display("FAIL sf1_drain out_v got %b want 0", b_out_v); end
  endtask

  task automatic test_mid_reset;
    a_out_rdy = 1;
    beat_a(1, 3); beat_a(1, 5);
    a_in_v = 0; rst = 1; #1;
    tests++; if (a_out_v !== 1'b0 || a_out_acc !== 8'h00) begin fails++;
      $display("FAIL rst_async got v=%b acc=%h want v=0 acc=00", a_out_v, a_out_acc); end
    @(posedge aclk); #1 rst = 0;
    for (int i = 0; i < 3; i++) begin
      beat_a(1, 1);
      tests++; if (a_out_v !== 1'b0) begin fails++;
        $display("FAIL rst_early_v beat %0d got %b want 0", i, a_out_v); end
    end
    beat_a(1, 1);
    tests++; if (a_out_v !== 1'b1 || a_out_acc !== fx(4, 32)) begin fails++;
      $display("FAIL rst_fresh_fold got v=%b acc=%h want v=1 acc=%h", a_out_v, a_out_acc, fx(4, 32)); end
    beat_a(0, 0);
  endtask

  initial begin
    test_reset;
    test_fold;
    test_back_to_back;
    test_backpressure;
    test_sf1;
    test_mid_reset;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
